// File: rtl/compute_op_responder.sv
// Single-op compute engine responder: accepts a start handshake, runs the op for a fixed per-op latency, pulses done.
// Optional performance counters are compiled in with `define COMPUTE_RESP_PERF_EN.
module compute_op_responder #(
  parameter int LAT_QK   = 3,
  parameter int LAT_SV   = 5,
  parameter int LAT_PROJ = 8
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        compute_start,
  input  logic        compute_start_ap_vld,
  input  logic [31:0] compute_op,
  input  logic        compute_op_ap_vld,
  input  logic        err_clr,
  output logic        compute_ready,
  output logic        compute_done,
  output logic        eng_busy,
  output logic [1:0]  eng_op,
  output logic        err_illegal_op,
  output logic        err_start_busy
`ifdef COMPUTE_RESP_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles,
  output logic [15:0] perf_ops_done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_err_illegal;
  logic        r_err_busy;

  logic        w_qual_start;
  logic        w_accept;
  logic        w_op_illegal;
  logic [1:0]  w_op_sel;
  logic [7:0]  w_cnt_load;

  // Op code 3 marks an illegal request; it runs with a single-cycle latency.
  function automatic logic [7:0] lat_load(input logic [1:0] op);
    case (op)
      2'd0:    lat_load = 8'(LAT_QK - 1);
      2'd1:    lat_load = 8'(LAT_SV - 1);
      2'd2:    lat_load = 8'(LAT_PROJ - 1);
      default: lat_load = 8'd0;
    endcase
  endfunction

  assign w_qual_start = compute_start && compute_start_ap_vld;
  assign w_accept     = w_qual_start && (r_state == S_IDLE);
  assign w_op_illegal = compute_op_ap_vld && (compute_op > 32'd2);
  assign w_op_sel     = !compute_op_ap_vld ? r_op :
                        (w_op_illegal ? 2'd3 : compute_op[1:0]);
  assign w_cnt_load   = lat_load(w_op_sel);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == 8'd0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_op    <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt <= w_cnt_load;
        r_op  <= w_op_sel;
      end else if (r_state == S_RUN && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_err_illegal <= 1'b0;
      r_err_busy    <= 1'b0;
    end else begin
      if (w_accept && w_op_illegal) r_err_illegal <= 1'b1;
      else if (err_clr)             r_err_illegal <= 1'b0;
      if (w_qual_start && r_state != S_IDLE) r_err_busy <= 1'b1;
      else if (err_clr)                      r_err_busy <= 1'b0;
    end
  end

  assign compute_ready  = (r_state == S_IDLE);
  assign eng_busy       = (r_state == S_RUN);
  assign compute_done   = (r_state == S_DONE);
  assign eng_op         = r_op;
  assign err_illegal_op = r_err_illegal;
  assign err_start_busy = r_err_busy;

`ifdef COMPUTE_RESP_PERF_EN
  logic [31:0] r_perf_busy;
  logic [15:0] r_perf_ops;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_perf_busy <= 32'd0;
      r_perf_ops  <= 16'd0;
    end else begin
      if (r_state == S_RUN && r_perf_busy != 32'hFFFF_FFFF)
        r_perf_busy <= r_perf_busy + 32'd1;
      if (r_state == S_DONE)
        r_perf_ops <= r_perf_ops + 16'd1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_ops_done    = r_perf_ops;
`endif

endmodule
